// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath control FSM
//
// Moore controller for a five-class multicycle datapath: lw, sw, R-type, beq and j.
// Optional feature macro: MC_ILLEGAL_TRAP_EN. When it is defined, an illegal opcode
// enters TRAP and stays there until reset. When it is undefined, an illegal opcode
// is treated as a NOP.
//
// Ports
//   clk                   rising-edge clock
//   reset                 synchronous active-high reset
//   op[5:0]               opcode from the instruction register
//   mem_ready             memory access completes this cycle
//   aluop2..aluop0        ALU-op class (000 add, 001 sub, 100 funct decode)
//   pcwrite, pcwritecond  PC write enables
//   iord                  memory address select (0 PC, 1 ALUOut)
//   memread, memwrite     memory strobes
//   memtoreg              register write data select (1 MDR)
//   irwrite               instruction register load
//   regdst                destination register select (1 rd)
//   regwrite              register file write enable
//   alusrca               ALU A select (1 reg A)
//   alusrcb[1:0]          ALU B select
//   pcsource[1:0]         next-PC select
//   state[3:0]            current state code
//   trap                  illegal-opcode indicator

module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       aluop2,
   output logic       aluop1,
   output logic       aluop0,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsource,
   output logic [3:0] state,
   output logic       trap
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RTWB   = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
`ifdef MC_ILLEGAL_TRAP_EN
      , TRAP = 4'd10
`endif
   } state_t;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_RT  = 6'b000000;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   state_t     cur, nxt;
   logic [2:0] aluop;

   always_ff @(posedge clk) begin
      if (reset) cur <= FETCH;
      else       cur <= nxt;
   end

   always_comb begin
      nxt         = FETCH;
      aluop       = 3'b000;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      memtoreg    = 1'b0;
      irwrite     = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsource    = 2'b00;
      trap        = 1'b0;

      case (cur)
         FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            nxt     = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_RT:        nxt = EXEC;
               OP_BEQ:       nxt = BRANCH;
               OP_J:         nxt = JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
               default:      nxt = TRAP;
`else
               default:      nxt = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            // op is stable here; anything other than sw was an lw
            nxt     = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            nxt     = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
            nxt      = mem_ready ? FETCH : MEMWR;
         end
         EXEC: begin
            alusrca = 1'b1;
            aluop   = 3'b100;
            nxt     = RTWB;
         end
         RTWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         BRANCH: begin
            alusrca     = 1'b1;
            aluop       = 3'b001;
            pcwritecond = 1'b1;
            pcsource    = 2'b01;
         end
         JUMP: begin
            pcwrite  = 1'b1;
            pcsource = 2'b10;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         TRAP: begin
            trap = 1'b1;
            nxt  = TRAP;
         end
`endif
         // unused codes recover to FETCH with every enable low
         default: nxt = FETCH;
      endcase

      // reset gates side-effecting strobes in the same cycle, even mid-handshake
      if (reset) begin
         pcwrite     = 1'b0;
         pcwritecond = 1'b0;
         memread     = 1'b0;
         memwrite    = 1'b0;
         irwrite     = 1'b0;
         regwrite    = 1'b0;
         trap        = 1'b0;
         aluop       = 3'b000;
      end
   end

   assign aluop2 = aluop[2];
   assign aluop1 = aluop[1];
   assign aluop0 = aluop[0];
   assign state  = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control

module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;
   logic       aluop2, aluop1, aluop0;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
   logic       irwrite, regdst, regwrite, alusrca;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] state;
   logic       trap;

   int checks = 0;
   int errors = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .aluop2(aluop2), .aluop1(aluop1), .aluop0(aluop0),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
      .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
      .irwrite(irwrite), .regdst(regdst), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
      .state(state), .trap(trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [2:0] aluop();
      return {aluop2, aluop1, aluop0};
   endfunction

   initial begin
      reset     = 1'b1;
      op        = 6'b100011;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      tick();
      // in reset the state register holds FETCH but strobes are forced low
      chk("rst_state",   state,   4'd0);
      chk("rst_memread", memread, 1'b0);
      chk("rst_irwrite", irwrite, 1'b0);
      chk("rst_pcwrite", pcwrite, 1'b0);
      chk("rst_aluop",   aluop(), 3'b000);

      // lw: 0,1,2,3,4,0
      reset = 1'b0;
      #1;
      chk("lw_s0",        state,   4'd0);
      chk("lw_s0_mrd",    memread, 1'b1);
      chk("lw_s0_irw",    irwrite, 1'b1);
      chk("lw_s0_pcw",    pcwrite, 1'b1);
      chk("lw_s0_srcb",   alusrcb, 2'b01);
      tick();
      chk("lw_s1",        state,   4'd1);
      chk("lw_s1_srcb",   alusrcb, 2'b11);
      chk("lw_s1_aluop",  aluop(), 3'b000);
      tick();
      chk("lw_s2",        state,   4'd2);
      chk("lw_s2_srca",   alusrca, 1'b1);
      chk("lw_s2_srcb",   alusrcb, 2'b10);
      chk("lw_s2_rw",     regwrite, 1'b0);
      tick();
      chk("lw_s3",        state,   4'd3);
      chk("lw_s3_mrd",    memread, 1'b1);
      chk("lw_s3_iord",   iord,    1'b1);
      chk("lw_s3_rw",     regwrite, 1'b0);
      tick();
      chk("lw_s4",        state,    4'd4);
      chk("lw_s4_rw",     regwrite, 1'b1);
      chk("lw_s4_m2r",    memtoreg, 1'b1);
      chk("lw_s4_rdst",   regdst,   1'b0);
      chk("lw_s4_aluop",  aluop(),  3'b000);

      // R-type: 0,1,6,7,0
      op = 6'b000000;
      tick();
      chk("rt_s0",        state,   4'd0);
      chk("rt_s0_rw",     regwrite, 1'b0);
      tick();
      chk("rt_s1",        state,   4'd1);
      chk("rt_s1_aluop",  aluop(), 3'b000);
      tick();
      chk("rt_s6",        state,   4'd6);
      chk("rt_s6_aluop",  aluop(), 3'b100);
      chk("rt_s6_srca",   alusrca, 1'b1);
      chk("rt_s6_srcb",   alusrcb, 2'b00);
      tick();
      chk("rt_s7",        state,    4'd7);
      chk("rt_s7_aluop",  aluop(),  3'b000);
      chk("rt_s7_rw",     regwrite, 1'b1);
      chk("rt_s7_rdst",   regdst,   1'b1);
      chk("rt_s7_m2r",    memtoreg, 1'b0);

      // beq: 0,1,8,0
      op = 6'b000100;
      tick();
      chk("beq_s0",       state,   4'd0);
      tick();
      chk("beq_s1",       state,   4'd1);
      tick();
      chk("beq_s8",       state,       4'd8);
      chk("beq_s8_aluop", aluop(),     3'b001);
      chk("beq_s8_pwc",   pcwritecond, 1'b1);
      chk("beq_s8_psrc",  pcsource,    2'b01);
      chk("beq_s8_srca",  alusrca,     1'b1);
      chk("beq_s8_pcw",   pcwrite,     1'b0);

      // j: 0,1,9,0
      op = 6'b000010;
      tick();
      chk("j_s0",         state,   4'd0);
      tick();
      chk("j_s1",         state,   4'd1);
      tick();
      chk("j_s9",         state,    4'd9);
      chk("j_s9_pcw",     pcwrite,  1'b1);
      chk("j_s9_psrc",    pcsource, 2'b10);
      chk("j_s9_mrd",     memread,  1'b0);

      // FETCH stall for 3 cycles, then illegal opcode
      mem_ready = 1'b0;
      op        = 6'b111111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_state", state,   4'd0);
         chk("stall_irw",   irwrite, 1'b0);
         chk("stall_pcw",   pcwrite, 1'b0);
      end
      mem_ready = 1'b1;
      #1;
      chk("stall_end_state", state,   4'd0);
      chk("stall_end_irw",   irwrite, 1'b1);
      chk("stall_end_pcw",   pcwrite, 1'b1);
      tick();
      chk("ill_s1",       state, 4'd1);
      chk("ill_s1_trap",  trap,  1'b0);
      tick();
`ifdef MC_ILLEGAL_TRAP_EN
      chk("ill_s10",      state, 4'd10);
      chk("ill_trap",     trap,  1'b1);
      chk("ill_mrd",      memread, 1'b0);
      tick();
      chk("ill_hold",     state, 4'd10);
      chk("ill_hold_trap", trap, 1'b1);
      reset = 1'b1;
      #1;
      chk("ill_rst_trap", trap, 1'b0);
      tick();
      chk("ill_rst_state", state, 4'd0);
      reset = 1'b0;
      #1;
`else
      chk("ill_nop_state", state, 4'd0);
      chk("ill_nop_trap",  trap,  1'b0);
`endif

      // sw with reset landing mid-handshake in MEMWR
      op = 6'b101011;
      tick();
      chk("sw_s1",        state, 4'd1);
      tick();
      chk("sw_s2",        state, 4'd2);
      mem_ready = 1'b0;
      tick();
      chk("sw_s5",        state,    4'd5);
      chk("sw_s5_mw",     memwrite, 1'b1);
      chk("sw_s5_iord",   iord,     1'b1);
      tick();
      chk("sw_s5_wait",   state,    4'd5);
      reset = 1'b1;
      #1;
      chk("sw_rst_mw",    memwrite, 1'b0);
      tick();
      chk("sw_rst_state", state,    4'd0);
      reset     = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("post_rst_mrd", memread,  1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
